// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit multi-cycle CPU: opcodes, ALU functions,
// controller states and datapath mux selects.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_LW   = 4'h5,
    OP_SW   = 4'h6,
    OP_BEQ  = 4'h7,
    OP_J    = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] PC_SRC_PLUS1  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] ALU_B_RT  = 2'd0;
  localparam logic [1:0] ALU_B_IMM = 2'd1;
  localparam logic [1:0] ALU_B_ONE = 2'd2;

  // Codes 9..E are unassigned and trap to HALT.
  function automatic logic is_legal(input logic [3:0] op);
    return (op <= 4'h8) || (op == 4'hF);
  endfunction

  // R-type opcodes 0..3 carry the ALU function in their low two bits.
  function automatic alu_op_e rtype_alu_op(input logic [3:0] op);
    case (op[1:0])
      2'd0:    return ALU_ADD;
      2'd1:    return ALU_SUB;
      2'd2:    return ALU_AND;
      default: return ALU_OR;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_timer.sv
// Memory wait timer: counts cycles a request waits for mem_ready and flags the
// last permitted waiting cycle. MEM_TIMEOUT = 0 disables the guard.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CW-1:0] count;

  // expired marks the MEM_TIMEOUT-th waiting cycle; a mem_ready in that same
  // cycle still completes the access because the FSM checks ready first.
  assign expired = (MEM_TIMEOUT != 0) && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives every
// datapath strobe and mux select, with a guarded req/ready memory handshake.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          instr_opcode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_op,
  output logic                reg_write,
  output logic                wb_src,
  output logic                halted,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [RETIRE_W-1:0] retired,
  output logic [2:0]          state_dbg
);

  state_e state;
  state_e state_next;
  logic   waiting;
  logic   timer_expired;
  logic   retire;
  logic   set_illegal;
  logic   set_bus_error;

  // Handshake: mem_req is high for the whole of FETCH and MEM; an access
  // completes on the first cycle mem_ready is sampled high while mem_req is
  // high. mem_ready in any other state is ignored.
  assign waiting = (state == S_FETCH) || (state == S_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!waiting || mem_ready),
    .en     (waiting && !mem_ready),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired    <= '0;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      if (retire)        retired    <= retired + 1'b1;
      if (set_illegal)   illegal_op <= 1'b1;
      if (set_bus_error) bus_error  <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timer_expired) begin
          state_next    = S_HALT;
          set_bus_error = 1'b1;
        end
      end
      S_DECODE: begin
        if (instr_opcode == OP_HALT) begin
          state_next = S_HALT;
        end else if (instr_opcode == OP_J) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end else if (!is_legal(instr_opcode)) begin
          state_next  = S_HALT;
          set_illegal = 1'b1;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (instr_opcode == OP_LW || instr_opcode == OP_SW) begin
          state_next = S_MEM;
        end else if (instr_opcode == OP_BEQ) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (instr_opcode == OP_SW) begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end else if (timer_expired) begin
          state_next    = S_HALT;
          set_bus_error = 1'b1;
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_src = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PLUS1;
    alu_src_b    = ALU_B_RT;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    wb_src       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ALU_B_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        if (instr_opcode == OP_J) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end
      end
      S_EXEC: begin
        if (instr_opcode <= OP_OR) begin
          alu_src_b = ALU_B_RT;
          alu_op    = rtype_alu_op(instr_opcode);
        end else if (instr_opcode == OP_BEQ) begin
          alu_src_b = ALU_B_RT;
          alu_op    = ALU_SUB;
          pc_src    = PC_SRC_BRANCH;
          pc_write  = alu_zero;
        end else begin
          alu_src_b = ALU_B_IMM;
          alu_op    = ALU_ADD;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_we       = (instr_opcode == OP_SW);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_src    = (instr_opcode == OP_LW);
      end
      default: ;
    endcase
    // Nothing may strobe while reset is held, even though state reads FETCH.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign halted    = (state == S_HALT);
  assign state_dbg = state;

endmodule
